int_flag_controller: RTL and testbench
======================================

Name: int_flag_controller

Overview:
- Interrupt sequencer for the pico core.
- Latches and prioritises external interrupt requests, then takes an interrupt at an instruction boundary.
- On entry, saves the carry/zero condition flags into shadow registers. On RETI, drives the saved flags back to the condition-code register via its int_c/int_z/reti inputs.
- Sits between the decoder/PC logic and the condition-code register.

Parameters:
NUM_IRQ, 4, number of interrupt sources (index 0 = highest priority)
ADDR_W, 8, width of program address / vector output
VEC_BASE, 8'h04, address of vector for source 0
VEC_STRIDE, 2, address spacing between consecutive vectors

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
irq  input  NUM_IRQ  external request lines, rising-edge sensitive
mask_we  input  1  write strobe for mask register
mask_wdata  input  NUM_IRQ  new mask value (1 = source masked)
instr_done  input  1  current instruction completes this cycle (boundary)
reti_req  input  1  decoder has a RETI instruction in execute
cc_c  input  1  current carry flag from condition-code register
cc_z  input  1  current zero flag from condition-code register
int_c  output  1  saved carry, to cc_int_c
int_z  output  1  saved zero, to cc_int_z
reti_signal  output  1  one-cycle restore strobe, to cc_reti_signal
stall  output  1  hold PC/fetch this cycle
pc_save  output  1  push return PC this cycle
vector_valid  output  1  vector_addr is valid, load PC
vector_addr  output  ADDR_W  ISR entry address
irq_ack  output  NUM_IRQ  one-hot acknowledge of serviced source
in_isr  output  1  core is executing an ISR
mask  output  NUM_IRQ  current mask register

Behaviour:
- Reset (synchronous, high; also mid-operation):
  - state = IDLE; pending = 0; irq_prev = 0; mask = all ones; ie = 1; shadow flags = 0.
  - Every output = 0, except mask = all ones.
  - An irq line already high when reset deasserts counts as a rising edge on the first cycle after reset.
- Edge capture, every cycle: pending[i] <= 1 when irq[i] & ~irq_prev[i]; irq_prev <= irq.
- Mask: mask_we writes mask next cycle, in any state. Masked sources still latch pending; they just cannot be selected.
- eligible = pending & ~mask. sel = lowest set index of eligible.
- FSM states: IDLE, ENTRY, ISR, RETURN.
- IDLE:
  - When ie & |eligible & instr_done: shadow_c <= cc_c; shadow_z <= cc_z; sel_r <= sel; ie <= 0; go to ENTRY.
  - reti_req in IDLE is ignored (no strobe).
- ENTRY, exactly 1 cycle:
  - stall = 1, pc_save = 1, vector_valid = 1.
  - vector_addr = VEC_BASE + sel_r*VEC_STRIDE, truncated to ADDR_W.
  - irq_ack = one-hot(sel_r).
  - pending[sel_r] cleared at the cycle end, unless a new rising edge on that same line occurs this cycle (set wins).
  - Next state: ISR.
- ISR:
  - in_isr = 1.
  - No nesting: further eligible requests stay pending.
  - When reti_req & instr_done: go to RETURN.
- RETURN, exactly 1 cycle:
  - reti_signal = 1, stall = 1, in_isr = 1.
  - ie <= 1; next state IDLE.
  - Condition-code register loads int_c/int_z on this edge.
- int_c/int_z continuously drive shadow_c/shadow_z, not only during RETURN.
- Latency:
  - Boundary cycle → ENTRY: next cycle.
  - ENTRY → ISR: 1 cycle.
  - Earliest re-entry after RETURN: the IDLE cycle following RETURN, if instr_done.
- Outputs other than mask are decoded from state and sel_r (registered state, no combinational path from irq).

Test Plan:
- Reset/idle: hold reset 2 cycles with irq=4'b0011 → all outputs 0, mask=4'hF. After reset with mask_we, mask_wdata=0: pending=0011 is captured.
- Single IRQ: mask=0, pulse irq[2], instr_done=1, cc_c=1, cc_z=0 → ENTRY next cycle with vector_addr=8'h08, irq_ack=4'b0100, pc_save=stall=1. Then in_isr=1, int_c=1, int_z=0.
- Priority/no-nesting: irq[3] and irq[1] rise the same cycle → source 1 serviced first (vector 8'h06). Source 3 is serviced only after RETURN (vector 8'h0A).
- RETI restore: in ISR, set cc_c=0, cc_z=1; assert reti_req and instr_done → reti_signal=1 for exactly 1 cycle with int_c=1, int_z=0; then IDLE and ie=1.
- Masking/boundary: irq[0] pending, mask[0]=1 → no entry. Clear the mask with instr_done=0 → no entry until the first instr_done=1 cycle. reti_req in IDLE → reti_signal stays 0.
- Reset mid-ISR: assert reset during ISR → IDLE, in_isr=0, pending=0, shadow=0 on the next cycle.

Source files
------------

// File: rtl/int_flag_controller.sv
// Interrupt sequencer: edge-captures requests, enters the highest-priority unmasked
// source at an instruction boundary, and shadows carry/zero across the ISR for RETI.
module int_flag_controller #(
  parameter int                 NUM_IRQ    = 4,
  parameter int                 ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = 8'h04,
  parameter int unsigned        VEC_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               instr_done,
  input  logic               reti_req,
  input  logic               cc_c,
  input  logic               cc_z,
  output logic               int_c,
  output logic               int_z,
  output logic               reti_signal,
  output logic               stall,
  output logic               pc_save,
  output logic               vector_valid,
  output logic [ADDR_W-1:0]  vector_addr,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic [NUM_IRQ-1:0] mask
);

  localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_ISR    = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_prev;
  logic               ie;
  logic               shadow_c;
  logic               shadow_z;
  logic [SEL_W-1:0]   sel_r;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic [SEL_W-1:0]   sel;
  logic               take;

  assign eligible   = pending & ~mask;
  assign rise       = irq & ~irq_prev;
  assign sel_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << sel_r;
  assign take       = (state == S_IDLE) && ie && (|eligible) && instr_done;

  // Scan from the top so the lowest eligible index ends up winning.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (take) state_next = S_ENTRY;
      S_ENTRY:  state_next = S_ISR;
      S_ISR:    if (reti_req && instr_done) state_next = S_RETURN;
      S_RETURN: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pending  <= '0;
      irq_prev <= '0;
      mask     <= '1;
      ie       <= 1'b1;
      shadow_c <= 1'b0;
      shadow_z <= 1'b0;
      sel_r    <= '0;
    end else begin
      state    <= state_next;
      irq_prev <= irq;
      // A fresh edge on the serviced line during ENTRY survives the clear.
      pending  <= (pending & ~((state == S_ENTRY) ? sel_onehot : '0)) | rise;
      if (mask_we) mask <= mask_wdata;
      if (take) begin
        shadow_c <= cc_c;
        shadow_z <= cc_z;
        sel_r    <= sel;
        ie       <= 1'b0;
      end else if (state == S_RETURN) begin
        ie <= 1'b1;
      end
    end
  end

  assign int_c = shadow_c;
  assign int_z = shadow_z;

  always_comb begin
    reti_signal  = 1'b0;
    stall        = 1'b0;
    pc_save      = 1'b0;
    vector_valid = 1'b0;
    vector_addr  = '0;
    irq_ack      = '0;
    in_isr       = 1'b0;
    case (state)
      S_ENTRY: begin
        stall        = 1'b1;
        pc_save      = 1'b1;
        vector_valid = 1'b1;
        vector_addr  = VEC_BASE + ADDR_W'(sel_r) * ADDR_W'(VEC_STRIDE);
        irq_ack      = sel_onehot;
      end
      S_ISR: in_isr = 1'b1;
      S_RETURN: begin
        reti_signal = 1'b1;
        stall       = 1'b1;
        in_isr      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_flag_controller.sv
// Directed plus randomized bench for int_flag_controller; a cycle-level behavioural
// model of request latching, priority, entry/return and flag shadowing supplies expectations.
module tb_int_flag_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       instr_done;
  logic       reti_req;
  logic       cc_c;
  logic       cc_z;
  logic       int_c;
  logic       int_z;
  logic       reti_signal;
  logic       stall;
  logic       pc_save;
  logic       vector_valid;
  logic [7:0] vector_addr;
  logic [3:0] irq_ack;
  logic       in_isr;
  logic [3:0] mask;

  int checks;
  int errors;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int_flag_controller dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .instr_done   (instr_done),
    .reti_req     (reti_req),
    .cc_c         (cc_c),
    .cc_z         (cc_z),
    .int_c        (int_c),
    .int_z        (int_z),
    .reti_signal  (reti_signal),
    .stall        (stall),
    .pc_save      (pc_save),
    .vector_valid (vector_valid),
    .vector_addr  (vector_addr),
    .irq_ack      (irq_ack),
    .in_isr       (in_isr),
    .mask         (mask)
  );

  // behavioural model: phase of interrupt handling plus per-source bits
  localparam int P_IDLE  = 0;
  localparam int P_ENTRY = 1;
  localparam int P_ISR   = 2;
  localparam int P_RET   = 3;

  int m_phase;
  int m_sel;
  bit m_pend[4];
  bit m_prev[4];
  bit m_mask[4];
  bit m_ie;
  bit m_sc;
  bit m_sz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_wd,
                            input logic i_done, input logic i_reti, input logic i_c,
                            input logic i_z, input logic i_rst);
    int winner;
    if (i_rst) begin
      m_phase = P_IDLE;
      m_sel   = 0;
      m_ie    = 1;
      m_sc    = 0;
      m_sz    = 0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
        m_mask[i] = 1;
      end
    end else begin
      winner = -1;
      for (int i = 0; i < 4; i++)
        if (winner < 0 && m_pend[i] && !m_mask[i]) winner = i;
      if (m_phase == P_ENTRY) m_pend[m_sel] = 0;
      for (int i = 0; i < 4; i++) begin
        if (i_irq[i] && !m_prev[i]) m_pend[i] = 1;
        m_prev[i] = i_irq[i];
      end
      case (m_phase)
        P_IDLE:
          if (m_ie && winner >= 0 && i_done) begin
            m_sc    = i_c;
            m_sz    = i_z;
            m_sel   = winner;
            m_ie    = 0;
            m_phase = P_ENTRY;
          end
        P_ENTRY: m_phase = P_ISR;
        P_ISR:   if (i_reti && i_done) m_phase = P_RET;
        default: begin
          m_ie    = 1;
          m_phase = P_IDLE;
        end
      endcase
      if (i_we)
        for (int i = 0; i < 4; i++) m_mask[i] = i_wd[i];
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_mask;
    bit ent;
    ent = (m_phase == P_ENTRY);
    for (int i = 0; i < 4; i++) exp_mask[i] = m_mask[i];
    chk("mask",         32'(mask),         32'(exp_mask));
    chk("int_c",        32'(int_c),        32'(m_sc));
    chk("int_z",        32'(int_z),        32'(m_sz));
    chk("reti_signal",  32'(reti_signal),  32'(m_phase == P_RET));
    chk("stall",        32'(stall),        32'(ent || m_phase == P_RET));
    chk("pc_save",      32'(pc_save),      32'(ent));
    chk("vector_valid", 32'(vector_valid), 32'(ent));
    chk("vector_addr",  32'(vector_addr),  ent ? 32'(4 + 2 * m_sel) : 32'd0);
    chk("irq_ack",      32'(irq_ack),      ent ? (32'd1 << m_sel) : 32'd0);
    chk("in_isr",       32'(in_isr),       32'(m_phase == P_ISR || m_phase == P_RET));
  endtask

  // driver: apply inputs, advance one clock, update model, then check after the edge
  task automatic step(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_wd,
                      input logic i_done, input logic i_reti, input logic i_c,
                      input logic i_z, input logic i_rst);
    irq        = i_irq;
    mask_we    = i_we;
    mask_wdata = i_wd;
    instr_done = i_done;
    reti_req   = i_reti;
    cc_c       = i_c;
    cc_z       = i_z;
    reset      = i_rst;
    @(posedge clk);
    model_edge(i_irq, i_we, i_wd, i_done, i_reti, i_c, i_z, i_rst);
    #1;
    check_all();
  endtask

  logic [3:0] r_irq;

  initial begin
    checks = 0;
    errors = 0;
    irq = '0; mask_we = 0; mask_wdata = '0; instr_done = 0;
    reti_req = 0; cc_c = 0; cc_z = 0; reset = 1;
    model_edge(4'b0, 0, 4'b0, 0, 0, 0, 0, 1);

    // reset with requests already high
    step(4'b0011, 0, 4'h0, 0, 0, 0, 0, 1);
    step(4'b0011, 0, 4'h0, 0, 0, 0, 0, 1);
    chk("rst_mask", 32'(mask), 32'hF);
    chk("rst_vvalid", 32'(vector_valid), 32'd0);
    step(4'b0011, 1, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0011, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("post_rst_vec", 32'(vector_addr), 32'h04);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("post_rst_vec1", 32'(vector_addr), 32'h06);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);

    // single request on source 2, then RETI restore
    step(4'b0100, 0, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 1, 0, 0);
    chk("single_vec", 32'(vector_addr), 32'h08);
    chk("single_ack", 32'(irq_ack), 32'b0100);
    chk("single_pcsave", 32'(pc_save), 32'd1);
    step(4'b0000, 0, 4'h0, 0, 0, 1, 0, 0);
    chk("single_in_isr", 32'(in_isr), 32'd1);
    chk("single_int_c", 32'(int_c), 32'd1);
    step(4'b0000, 0, 4'h0, 1, 1, 0, 1, 0);
    chk("reti_strobe", 32'(reti_signal), 32'd1);
    chk("reti_int_c", 32'(int_c), 32'd1);
    chk("reti_int_z", 32'(int_z), 32'd0);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 1, 0);
    chk("reti_one_cycle", 32'(reti_signal), 32'd0);

    // priority and no nesting: sources 3 and 1 together
    step(4'b1010, 0, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("prio_vec1", 32'(vector_addr), 32'h06);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("no_nest", 32'(vector_valid), 32'd0);
    step(4'b0000, 0, 4'h0, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("prio_vec3", 32'(vector_addr), 32'h0A);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);

    // masking, boundary wait, RETI ignored in idle
    step(4'b0000, 1, 4'b0001, 0, 0, 0, 0, 0);
    step(4'b0001, 0, 4'h0, 1, 0, 0, 0, 0);
    step(4'b0001, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("masked_no_entry", 32'(vector_valid), 32'd0);
    step(4'b0001, 0, 4'h0, 1, 1, 0, 0, 0);
    chk("idle_reti", 32'(reti_signal), 32'd0);
    step(4'b0001, 1, 4'h0, 0, 0, 0, 0, 0);
    step(4'b0001, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("wait_boundary", 32'(vector_valid), 32'd0);
    step(4'b0001, 0, 4'h0, 1, 0, 1, 1, 0);
    chk("unmask_vec", 32'(vector_addr), 32'h04);
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("isr_shadow", 32'({int_c, int_z}), 32'b11);

    // reset in the middle of the ISR
    step(4'b0000, 0, 4'h0, 0, 0, 0, 0, 1);
    chk("midrst_in_isr", 32'(in_isr), 32'd0);
    chk("midrst_shadow", 32'({int_c, int_z}), 32'b00);
    step(4'b0000, 1, 4'h0, 1, 0, 0, 0, 0);
    step(4'b0000, 0, 4'h0, 1, 0, 0, 0, 0);
    chk("midrst_pending", 32'(vector_valid), 32'd0);

    // randomized traffic against the model
    r_irq = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
      step(r_irq,
           ($urandom_range(0, 11) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
